// File: rtl/can_pkg.sv
// CAN shared types: frame bundle, RX register offsets, data-phase states.
// The CAN_RX_FILTER_EN build adds the MASK/MATCH offsets to the RX decoder.
package can_pkg;

  typedef struct packed {
    logic [63:0] data;
    logic [28:0] id;
    logic [3:0]  dlc;
    logic        fmt;
    logic [1:0]  ftype;
  } can_frame_t;

  localparam logic [4:0] REG_DL    = 5'h00;
  localparam logic [4:0] REG_DH    = 5'h04;
  localparam logic [4:0] REG_CMD   = 5'h08;
  localparam logic [4:0] REG_ID    = 5'h0C;
  localparam logic [4:0] REG_STAT  = 5'h10;
  localparam logic [4:0] REG_CTRL  = 5'h14;
  localparam logic [4:0] REG_MASK  = 5'h18;
  localparam logic [4:0] REG_MATCH = 5'h1C;

  typedef enum logic [1:0] {
    DP_IDLE,
    DP_WR,
    DP_RD
  } dp_state_t;

endpackage

// File: rtl/can_rx_fifo.sv
// Receive frame FIFO; dout is the head entry and is valid without a pop.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module can_rx_fifo
  import can_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  can_frame_t    din_i,
  output can_frame_t    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  can_frame_t    mem_q [DEPTH];
  logic [LW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + LW'(1);
    if (pop_i)  rptr_d = rptr_q + LW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == LW'(DEPTH));
  assign empty_o = (wptr_q == rptr_q);

endmodule

// File: rtl/can_rx_ahb.sv
// AHB slave front end for the CAN receive path with a frame FIFO.
// Define CAN_RX_FILTER_EN to add the RX_MASK/RX_MATCH identifier filter.
module can_rx_ahb
  import can_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter logic [15:0] BASE  = 16'hFF20
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  input  logic        rxValid,
  input  logic [63:0] rxdata,
  input  logic [28:0] rxid,
  input  logic [3:0]  rxdatalen,
  input  logic        rxformat,
  input  logic [1:0]  rxframeType,
  output logic        rxIrq
);

  localparam int LW = $clog2(DEPTH) + 1;

  dp_state_t     state_q, state_d;
  logic [4:0]    addr_q;
  logic [15:0]   off;
  logic          accept;
  logic          rd_en, wr_en;
  logic          sel_dl, sel_dh, sel_cmd, sel_id;
  logic          sel_stat, sel_ctrl;
  logic          en_q, ie_q, irq_q;
  logic [7:0]    ovf_q, ovf_d;
  logic          pop, push, rx_ok, ovf_inc, ovf_clr;
  logic          filt_ok;
  logic          full, empty;
  logic [LW-1:0] level;
  can_frame_t    din, head;
  logic          unused_w;

  assign HREADY = 1'b1;
  assign HRESP  = 2'b00;
  assign rxIrq  = irq_q;

  assign off    = HADDR[15:0] - BASE;
  assign accept = HSEL & HTRANS[1] & (off[15:5] == '0);

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q <= DP_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) addr_q <= off[4:0];
    end
  end

  always_comb begin
    state_d = DP_IDLE;
    if (accept) state_d = HWRITE ? DP_WR : DP_RD;
  end

  assign sel_dl   = (addr_q == REG_DL);
  assign sel_dh   = (addr_q == REG_DH);
  assign sel_cmd  = (addr_q == REG_CMD);
  assign sel_id   = (addr_q == REG_ID);
  assign sel_stat = (addr_q == REG_STAT);
  assign sel_ctrl = (addr_q == REG_CTRL);

`ifdef CAN_RX_FILTER_EN
  logic [28:0] mask_q, match_q;
  logic        sel_mask, sel_match;

  assign sel_mask  = (addr_q == REG_MASK);
  assign sel_match = (addr_q == REG_MATCH);
  assign filt_ok   = (((rxid ^ match_q) & mask_q) == '0);

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      mask_q  <= '0;
      match_q <= '0;
    end else begin
      if (wr_en && sel_mask)  mask_q  <= HWDATA[31:3];
      if (wr_en && sel_match) match_q <= HWDATA[31:3];
    end
  end
`else
  assign filt_ok = 1'b1;
`endif

  always_comb begin
    rd_en  = (state_q == DP_RD);
    wr_en  = (state_q == DP_WR);
    HRDATA = '0;
    if (rd_en) begin
      unique case (1'b1)
        sel_dl:   HRDATA = head.data[31:0];
        sel_dh:   HRDATA = head.data[63:32];
        sel_cmd:  HRDATA = {20'b0, head.dlc, head.fmt,
                            head.ftype, 5'b0};
        sel_id:   HRDATA = {head.id, 3'b0};
        sel_stat: HRDATA = {16'b0, ovf_q, 1'b0, 5'(level),
                            full, ~empty};
        sel_ctrl: HRDATA = {30'b0, ie_q, en_q};
`ifdef CAN_RX_FILTER_EN
        sel_mask:  HRDATA = {mask_q, 3'b0};
        sel_match: HRDATA = {match_q, 3'b0};
`endif
        default:  HRDATA = '0;
      endcase
    end
  end

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign pop     = wr_en & sel_stat & HWDATA[0] & ~empty;
  assign ovf_clr = wr_en & sel_stat & HWDATA[1];
  assign rx_ok   = rxValid & en_q & filt_ok;
  assign push    = rx_ok & (~full | pop);
  assign ovf_inc = rx_ok & full & ~pop;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = '0;
    else if (ovf_inc && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && sel_ctrl) begin
        en_q <= HWDATA[0];
        ie_q <= HWDATA[1];
      end
      ovf_q <= ovf_d;
      irq_q <= ie_q & ~empty;
    end
  end

  assign din = '{data: rxdata, id: rxid, dlc: rxdatalen,
                 fmt: rxformat, ftype: rxframeType};

  can_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESET),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign unused_w = ^{HSIZE, HADDR[31:16], HTRANS[0], HWDATA};

endmodule
